fetch_bp_bid_alloc: RTL and testbench

Front-end producer of the branch-prediction record stream consumed by the execute-side branch result table.
- Allocates a 4-bit branch ID (BID) per predicted branch from an 8-slot in-order window. Low 3 bits index the slot; bit 3 is the wrap bit.
- Emits the registered prediction record (valid/bid/taken/hit/target).
- Frees slots on branch commit and rewinds the window on a branch override.
- Honours the override cooldown by throttling new allocations.

---
 rtl/fetch_bp_bid_alloc.sv | 144 ++++++++++++++
 tb/tb_fetch_bp_bid_alloc.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_bp_bid_alloc.sv
// Purpose: allocates branch IDs from an 8-slot in-order window and emits the prediction record.
// Latency: the prediction record appears exactly 1 cycle after an accepted request.
// Backpressure: o_fp_ready drops when the window is full, during cooldown, or on a same-cycle override.
module fetch_bp_bid_alloc #(
  parameter bit COOLDOWN_BLOCK = 1'b1,
  parameter int SLOTS_LOG2     = 3
) (
  input  logic                  clk,
  input  logic                  resetn,
  // Fetch-side prediction requests
  input  logic                  i_fp_valid,
  input  logic [31:0]           i_fp_pc,
  input  logic                  i_fp_taken,
  input  logic                  i_fp_hit,
  input  logic [31:0]           i_fp_target,
  output logic                  o_fp_ready,
  output logic [SLOTS_LOG2:0]   o_fp_bid,
  // Registered prediction record
  output logic                  o_bp_valid,
  output logic [SLOTS_LOG2:0]   o_bp_bid,
  output logic                  o_bp_taken,
  output logic                  o_bp_hit,
  output logic [31:0]           o_bp_target,
  // Commit / override from the result table
  input  logic                  i_bc_valid,
  input  logic [SLOTS_LOG2:0]   i_bc_bid,
  input  logic                  i_bco_valid,
  input  logic                  i_bco_cooldown,
  // Window status
  output logic                  o_head_valid,
  output logic [SLOTS_LOG2:0]   o_head_bid,
  output logic [31:0]           o_head_pc,
  output logic [SLOTS_LOG2:0]   o_inflight,
  output logic                  o_err_order
);

  localparam int                  SLOTS   = 1 << SLOTS_LOG2;
  localparam logic [SLOTS_LOG2:0] BID_ONE = {{SLOTS_LOG2{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [SLOTS_LOG2:0] head_q, head_d;
  logic [SLOTS_LOG2:0] tail_q, tail_d;
  logic                err_q, err_d;

  logic                bp_valid_q;
  logic [SLOTS_LOG2:0] bp_bid_q;
  logic                bp_taken_q;
  logic                bp_hit_q;
  logic [31:0]         bp_target_q;

  logic [31:0]         pc_mem [SLOTS];

  logic empty;
  logic full;
  logic ovr;
  logic fire;
  logic order_bad;

  assign empty = (tail_q == head_q);
  assign full  = (tail_q[SLOTS_LOG2-1:0] == head_q[SLOTS_LOG2-1:0]) &&
                 (tail_q[SLOTS_LOG2] != head_q[SLOTS_LOG2]);

  // Override only counts when qualified by a commit.
  assign ovr = i_bc_valid & i_bco_valid;

  // A same-cycle commit does not relieve full: ready depends on registered pointers only.
  assign o_fp_ready = ~full & ~(COOLDOWN_BLOCK & i_bco_cooldown) & ~ovr;
  assign fire       = i_fp_valid & o_fp_ready;

  // Commits must retire strictly in order from a non-empty window.
  assign order_bad = i_bc_valid & (empty | (i_bc_bid != head_q));

  assign o_fp_bid     = tail_q;
  assign o_head_valid = ~empty;
  assign o_head_bid   = head_q;
  assign o_head_pc    = pc_mem[head_q[SLOTS_LOG2-1:0]];
  assign o_inflight   = tail_q - head_q;
  assign o_err_order  = err_q;

  assign o_bp_valid  = bp_valid_q;
  assign o_bp_bid    = bp_bid_q;
  assign o_bp_taken  = bp_taken_q;
  assign o_bp_hit    = bp_hit_q;
  assign o_bp_target = bp_target_q;

  // Next pointers: an override rewinds both pointers past the overriding branch,
  // otherwise allocation moves the tail and a commit on a non-empty window moves the head.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    err_d  = err_q | order_bad;
    if (ovr) begin
      head_d = i_bc_bid + BID_ONE;
      tail_d = i_bc_bid + BID_ONE;
    end else begin
      if (fire) begin
        tail_d = tail_q + BID_ONE;
      end
      if (i_bc_valid && !empty) begin
        head_d = head_q + BID_ONE;
      end
    end
  end

  // Pointer and sticky error state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q <= '0;
      tail_q <= '0;
      err_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      err_q  <= err_d;
    end
  end

  // Prediction record: valid pulses for one cycle per accepted request, data fields hold.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bp_valid_q  <= 1'b0;
      bp_bid_q    <= '0;
      bp_taken_q  <= 1'b0;
      bp_hit_q    <= 1'b0;
      bp_target_q <= '0;
    end else begin
      bp_valid_q <= fire;
      if (fire) begin
        bp_bid_q    <= tail_q;
        bp_taken_q  <= i_fp_taken;
        bp_hit_q    <= i_fp_hit;
        bp_target_q <= i_fp_target;
      end
    end
  end

  // Branch PC storage per slot; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (fire) begin
      pc_mem[tail_q[SLOTS_LOG2-1:0]] <= i_fp_pc;
    end
  end

endmodule

// File: tb/tb_fetch_bp_bid_alloc.sv
module tb_fetch_bp_bid_alloc;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_fp_valid;
  logic [31:0] i_fp_pc;
  logic        i_fp_taken;
  logic        i_fp_hit;
  logic [31:0] i_fp_target;
  logic        i_bc_valid;
  logic [3:0]  i_bc_bid;
  logic        i_bco_valid;
  logic        i_bco_cooldown;

  logic        o_fp_ready, b_fp_ready;
  logic [3:0]  o_fp_bid, b_fp_bid;
  logic        o_bp_valid, b_bp_valid;
  logic [3:0]  o_bp_bid, b_bp_bid;
  logic        o_bp_taken, b_bp_taken;
  logic        o_bp_hit, b_bp_hit;
  logic [31:0] o_bp_target, b_bp_target;
  logic        o_head_valid, b_head_valid;
  logic [3:0]  o_head_bid, b_head_bid;
  logic [31:0] o_head_pc, b_head_pc;
  logic [3:0]  o_inflight, b_inflight;
  logic        o_err_order, b_err_order;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fetch_bp_bid_alloc #(.COOLDOWN_BLOCK(1'b1), .SLOTS_LOG2(3)) dut (
    .clk(clk), .resetn(resetn),
    .i_fp_valid(i_fp_valid), .i_fp_pc(i_fp_pc), .i_fp_taken(i_fp_taken),
    .i_fp_hit(i_fp_hit), .i_fp_target(i_fp_target),
    .o_fp_ready(o_fp_ready), .o_fp_bid(o_fp_bid),
    .o_bp_valid(o_bp_valid), .o_bp_bid(o_bp_bid), .o_bp_taken(o_bp_taken),
    .o_bp_hit(o_bp_hit), .o_bp_target(o_bp_target),
    .i_bc_valid(i_bc_valid), .i_bc_bid(i_bc_bid), .i_bco_valid(i_bco_valid),
    .i_bco_cooldown(i_bco_cooldown),
    .o_head_valid(o_head_valid), .o_head_bid(o_head_bid), .o_head_pc(o_head_pc),
    .o_inflight(o_inflight), .o_err_order(o_err_order)
  );

  fetch_bp_bid_alloc #(.COOLDOWN_BLOCK(1'b0), .SLOTS_LOG2(3)) dut_nocd (
    .clk(clk), .resetn(resetn),
    .i_fp_valid(i_fp_valid), .i_fp_pc(i_fp_pc), .i_fp_taken(i_fp_taken),
    .i_fp_hit(i_fp_hit), .i_fp_target(i_fp_target),
    .o_fp_ready(b_fp_ready), .o_fp_bid(b_fp_bid),
    .o_bp_valid(b_bp_valid), .o_bp_bid(b_bp_bid), .o_bp_taken(b_bp_taken),
    .o_bp_hit(b_bp_hit), .o_bp_target(b_bp_target),
    .i_bc_valid(i_bc_valid), .i_bc_bid(i_bc_bid), .i_bco_valid(i_bco_valid),
    .i_bco_cooldown(i_bco_cooldown),
    .o_head_valid(b_head_valid), .o_head_bid(b_head_bid), .o_head_pc(b_head_pc),
    .o_inflight(b_inflight), .o_err_order(b_err_order)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_fp_valid     = 1'b0;
    i_fp_pc        = 32'h0;
    i_fp_taken     = 1'b0;
    i_fp_hit       = 1'b0;
    i_fp_target    = 32'h0;
    i_bc_valid     = 1'b0;
    i_bc_bid       = 4'h0;
    i_bco_valid    = 1'b0;
    i_bco_cooldown = 1'b0;
  endtask

  // Reset pulse placed between clock edges.
  task automatic do_reset();
    clear_inputs();
    resetn = 1'b0;
    #2;
    resetn = 1'b1;
    #1;
  endtask

  task automatic alloc(input logic [31:0] pc);
    i_fp_valid  = 1'b1;
    i_fp_pc     = pc;
    i_fp_taken  = pc[2];
    i_fp_hit    = 1'b1;
    i_fp_target = pc + 32'h1000;
    tick();
    i_fp_valid  = 1'b0;
  endtask

  initial begin
    logic [3:0] h_exp;
    logic [3:0] t_exp;

    clear_inputs();
    resetn = 1'b0;
    #12;
    // ---- reset values
    chk("rst_fp_ready", o_fp_ready, 1);
    chk("rst_fp_bid", o_fp_bid, 0);
    chk("rst_inflight", o_inflight, 0);
    chk("rst_head_valid", o_head_valid, 0);
    chk("rst_bp_valid", o_bp_valid, 0);
    chk("rst_err", o_err_order, 0);
    @(negedge clk);
    resetn = 1'b1;
    tick();

    // ---- three back-to-back requests
    i_fp_valid = 1'b1; i_fp_pc = 32'h100; i_fp_taken = 1'b1; i_fp_hit = 1'b1; i_fp_target = 32'h2000;
    #1;
    chk("t1_fp_bid0", o_fp_bid, 0);
    chk("t1_ready0", o_fp_ready, 1);
    tick();
    chk("t1_bp_valid0", o_bp_valid, 1);
    chk("t1_bp_bid0", o_bp_bid, 0);
    chk("t1_bp_taken0", o_bp_taken, 1);
    chk("t1_bp_target0", o_bp_target, 32'h2000);
    i_fp_pc = 32'h104; i_fp_taken = 1'b0; i_fp_hit = 1'b0; i_fp_target = 32'h2004;
    tick();
    chk("t1_bp_bid1", o_bp_bid, 1);
    chk("t1_bp_taken1", o_bp_taken, 0);
    chk("t1_bp_hit1", o_bp_hit, 0);
    i_fp_pc = 32'h108; i_fp_hit = 1'b1; i_fp_target = 32'h2008;
    tick();
    chk("t1_bp_bid2", o_bp_bid, 2);
    chk("t1_bp_target2", o_bp_target, 32'h2008);
    i_fp_valid = 1'b0;
    #1;
    chk("t1_inflight", o_inflight, 3);
    chk("t1_head_pc", o_head_pc, 32'h100);
    chk("t1_head_bid", o_head_bid, 0);
    tick();
    chk("t1_bp_valid_drop", o_bp_valid, 0);
    chk("t1_bp_bid_hold", o_bp_bid, 2);

    // ---- fill to 8, commit while full does not free a slot that cycle
    for (int k = 3; k < 8; k++) alloc(32'h100 + 32'(4 * k));
    i_fp_valid = 1'b1; i_fp_pc = 32'h200; i_fp_target = 32'h3000;
    #1;
    chk("t2_full_ready", o_fp_ready, 0);
    chk("t2_full_bid", o_fp_bid, 8);
    chk("t2_full_inflight", o_inflight, 8);
    i_bc_valid = 1'b1; i_bc_bid = 4'd0;
    #1;
    chk("t2_commit_ready", o_fp_ready, 0);
    tick();
    chk("t2_no_accept", o_bp_valid, 0);
    chk("t2_head_after", o_head_bid, 1);
    i_bc_valid = 1'b0;
    #1;
    chk("t2_ready_next", o_fp_ready, 1);
    tick();
    chk("t2_bp_valid8", o_bp_valid, 1);
    chk("t2_bp_bid8", o_bp_bid, 8);
    chk("t2_inflight8", o_inflight, 8);
    chk("t2_head_pc1", o_head_pc, 32'h104);
    i_fp_valid = 1'b0;

    // ---- drain four, then 20 allocate/commit pairs across the wrap
    for (int k = 1; k < 5; k++) begin
      i_bc_valid = 1'b1; i_bc_bid = 4'(k);
      tick();
    end
    i_bc_valid = 1'b0;
    h_exp = 4'd5;
    t_exp = 4'd9;
    chk("t3_inflight_start", o_inflight, 4);
    for (int k = 0; k < 20; k++) begin
      i_fp_valid = 1'b1; i_fp_pc = 32'h400 + 32'(4 * k); i_fp_target = 32'h5000 + 32'(k);
      i_bc_valid = 1'b1; i_bc_bid = h_exp;
      #1;
      chk("t3_fp_bid", o_fp_bid, t_exp);
      tick();
      chk("t3_bp_bid", o_bp_bid, t_exp);
      chk("t3_inflight", o_inflight, 4);
      h_exp = h_exp + 4'd1;
      t_exp = t_exp + 4'd1;
    end
    i_fp_valid = 1'b0;
    chk("t3_head_wrap", o_head_bid, 9);
    chk("t3_tail_wrap", o_fp_bid, 13);
    for (int k = 9; k < 13; k++) begin
      i_bc_valid = 1'b1; i_bc_bid = 4'(k);
      tick();
    end
    i_bc_valid = 1'b0;
    #1;
    chk("t3_empty_head_valid", o_head_valid, 0);
    chk("t3_empty_inflight", o_inflight, 0);
    chk("t3_empty_ready", o_fp_ready, 1);
    for (int k = 0; k < 8; k++) alloc(32'h600 + 32'(4 * k));
    #1;
    chk("t3_full_wrap_ready", o_fp_ready, 0);
    chk("t3_full_wrap_inflight", o_inflight, 8);
    chk("t3_full_wrap_bid", o_fp_bid, 5);
    chk("t3_full_wrap_head_pc", o_head_pc, 32'h600);
    chk("t3_err_clean", o_err_order, 0);

    // ---- override rewinds the window
    do_reset();
    for (int k = 0; k < 5; k++) alloc(32'h700 + 32'(4 * k));
    i_fp_valid = 1'b1; i_fp_pc = 32'h800;
    i_bc_valid = 1'b1; i_bco_valid = 1'b1; i_bc_bid = 4'd0;
    #1;
    chk("t4_ovr_ready", o_fp_ready, 0);
    tick();
    i_bc_valid = 1'b0; i_bco_valid = 1'b0; i_fp_valid = 1'b0;
    #1;
    chk("t4_ovr_no_accept", o_bp_valid, 0);
    chk("t4_ovr_head", o_head_bid, 1);
    chk("t4_ovr_tail", o_fp_bid, 1);
    chk("t4_ovr_inflight", o_inflight, 0);
    chk("t4_ovr_head_valid", o_head_valid, 0);
    chk("t4_ovr_err", o_err_order, 0);
    i_bco_valid = 1'b1;
    #1;
    chk("t4_bco_alone_ready", o_fp_ready, 1);
    i_bco_valid = 1'b0;
    alloc(32'h900);
    chk("t4_next_bid", o_bp_bid, 1);
    chk("t4_next_valid", o_bp_valid, 1);

    // ---- cooldown throttling (second instance ignores cooldown)
    do_reset();
    i_fp_valid = 1'b1; i_fp_pc = 32'hA00; i_fp_target = 32'hB00;
    i_bco_cooldown = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t5_cd_ready", o_fp_ready, 0);
      chk("t5_nocd_ready", b_fp_ready, 1);
      tick();
      chk("t5_cd_bp_valid", o_bp_valid, 0);
      chk("t5_nocd_bp_valid", b_bp_valid, 1);
    end
    chk("t5_nocd_bid", b_bp_bid, 3);
    i_bco_cooldown = 1'b0;
    #1;
    chk("t5_cd_drop_ready", o_fp_ready, 1);
    tick();
    chk("t5_first_accept", o_bp_valid, 1);
    chk("t5_first_bid", o_bp_bid, 0);
    i_fp_valid = 1'b0;

    // ---- order error is sticky; async reset mid-cycle
    do_reset();
    for (int k = 0; k < 4; k++) alloc(32'hC00 + 32'(4 * k));
    i_bc_valid = 1'b1; i_bc_bid = 4'd3;
    tick();
    i_bc_valid = 1'b0;
    chk("t6_err_set", o_err_order, 1);
    chk("t6_head_adv", o_head_bid, 1);
    tick();
    tick();
    chk("t6_err_sticky", o_err_order, 1);
    i_fp_valid = 1'b1; i_fp_pc = 32'hD00; i_fp_target = 32'hE00;
    tick();
    chk("t6_pre_rst_bp_valid", o_bp_valid, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("t6_arst_bp_valid", o_bp_valid, 0);
    chk("t6_arst_bp_bid", o_bp_bid, 0);
    chk("t6_arst_bp_target", o_bp_target, 0);
    chk("t6_arst_err", o_err_order, 0);
    chk("t6_arst_fp_bid", o_fp_bid, 0);
    chk("t6_arst_inflight", o_inflight, 0);
    chk("t6_arst_head_valid", o_head_valid, 0);
    chk("t6_arst_ready", o_fp_ready, 1);
    i_fp_valid = 1'b0;
    #1;
    resetn = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
